// File: rtl/adc_ctrl_pkg.sv
// adc_ctrl_pkg: shared state encoding and burst-length constants for the ADC conversion sequencer.
package adc_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CNV, CONV_WAIT, READ, SETTLE, LATCH, VALID} state_t;
  localparam logic [3:0] NCLK_1L_16 = 4'd8;
  localparam logic [3:0] NCLK_1L_18 = 4'd9;
  localparam logic [3:0] NCLK_2L_16 = 4'd4;
  localparam logic [3:0] NCLK_2L_18 = 4'd5;
  function automatic logic [3:0] nclk(input logic bits_18, input logic two_lane);
    return two_lane ? (bits_18 ? NCLK_2L_18 : NCLK_2L_16) : (bits_18 ? NCLK_1L_18 : NCLK_1L_16);
  endfunction
endpackage

// File: rtl/adc_period_timer.sv
// adc_period_timer: enable-gated wrapping sample-period counter emitting a one-cycle start pulse.
module adc_period_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  output logic             start
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  assign last = period == '0 ? '0 : period - CNT_W'(1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      start <= 1'b0;
    end else begin
      cnt   <= (!enable || cnt >= last) ? '0 : cnt + CNT_W'(1);
      start <= enable && cnt == '0;
    end
  end
endmodule

// File: rtl/adc_conv_ctrl.sv
// adc_conv_ctrl: per-period CNV / conversion wait / gated ADC CLK burst / LATCH sequencer.
module adc_conv_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int CNV_HIGH    = 2,
  parameter int CONV_CYCLES = 13,
  parameter int LATCH_DELAY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             bits_18,
  input  logic             two_lane,
  input  logic [CNT_W-1:0] period,
  input  logic             clear_overrun,
  output logic             cnv,
  output logic             clk_en,
  output logic             latch,
  output logic             sample_valid,
  output logic             busy,
  output logic             overrun
);
  localparam int TW = $clog2(CONV_CYCLES + int'(NCLK_1L_18) + LATCH_DELAY + 2);
  state_t        state;
  logic          start;
  logic          go;
  logic          bits_q;
  logic          two_q;
  logic [TW-1:0] t;
  logic [TW-1:0] read_end;
  logic [TW-1:0] settle_end;
  adc_period_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .period (period),
    .start  (start)
  );
  assign go         = start & enable;
  // t counts cycles since the cnv rise; every phase boundary is a fixed offset from it
  assign read_end   = TW'(CONV_CYCLES - 1) + TW'(nclk(bits_q, two_q));
  assign settle_end = read_end + TW'(LATCH_DELAY);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      t            <= '0;
      bits_q       <= 1'b0;
      two_q        <= 1'b0;
      cnv          <= 1'b0;
      clk_en       <= 1'b0;
      latch        <= 1'b0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      t       <= t + TW'(1);
      overrun <= (go && state != IDLE) ? 1'b1 : clear_overrun ? 1'b0 : overrun;
      case (state)
        IDLE: if (go) begin
          state  <= CNV;
          t      <= '0;
          bits_q <= bits_18;
          two_q  <= two_lane;
          cnv    <= 1'b1;
          busy   <= 1'b1;
        end
        CNV: if (t == TW'(CNV_HIGH - 1)) begin
          state <= CONV_WAIT;
          cnv   <= 1'b0;
        end
        CONV_WAIT: if (t == TW'(CONV_CYCLES - 1)) begin
          state  <= READ;
          clk_en <= 1'b1;
        end
        READ: if (t == read_end) begin
          state  <= LATCH_DELAY == 0 ? LATCH : SETTLE;
          clk_en <= 1'b0;
          latch  <= LATCH_DELAY == 0;
        end
        SETTLE: if (t == settle_end) begin
          state <= LATCH;
          latch <= 1'b1;
        end
        LATCH: begin
          state        <= VALID;
          latch        <= 1'b0;
          sample_valid <= 1'b1;
        end
        VALID: begin
          state        <= IDLE;
          sample_valid <= 1'b0;
          busy         <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_conv_ctrl.sv
// tb_adc_conv_ctrl: directed + randomized checks of adc_conv_ctrl against a cycle-offset timing model.
module tb_adc_conv_ctrl;
  localparam int CNT_W       = 16;
  localparam int CNV_HIGH    = 2;
  localparam int CONV_CYCLES = 13;
  localparam int LATCH_DELAY = 4;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             bits_18 = 1'b0;
  logic             two_lane = 1'b0;
  logic [CNT_W-1:0] period = 16'd100;
  logic             clear_overrun = 1'b0;
  logic             cnv, clk_en, latch, sample_valid, busy, overrun;
  int checks = 0;
  int failures = 0;
  longint cyc = 0;
  longint s_at = -1000;
  int n = 8;
  int run = 0;
  bit ov = 1'b0;
  adc_conv_ctrl #(
    .CNT_W(CNT_W), .CNV_HIGH(CNV_HIGH), .CONV_CYCLES(CONV_CYCLES), .LATCH_DELAY(LATCH_DELAY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bits_18(bits_18), .two_lane(two_lane),
    .period(period), .clear_overrun(clear_overrun), .cnv(cnv), .clk_en(clk_en), .latch(latch),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask
  // Expected outputs are pure functions of the offset from the latest cnv rise
  task automatic tick();
    longint d = cyc - s_at;
    int l = CONV_CYCLES + n + LATCH_DELAY;
    bit bsy = d >= 0 && d <= l + 1;
    int p = period == '0 ? 1 : int'(period);
    bit go = enable && run >= 1 && (run - 1) % p == 0;
    if (!rst_n) begin
      s_at = -1000;
      ov = 1'b0;
      run = 0;
    end else begin
      if (go && bsy) ov = 1'b1;
      else if (clear_overrun) ov = 1'b0;
      if (go && !bsy) begin
        s_at = cyc + 1;
        n = ((bits_18 ? 18 : 16) / (two_lane ? 2 : 1) + 1) / 2;
      end
      run = enable ? run + 1 : 0;
    end
    @(negedge clk);
    cyc++;
    d = cyc - s_at;
    l = CONV_CYCLES + n + LATCH_DELAY;
    check("cnv", cnv, d >= 0 && d < CNV_HIGH);
    check("clk_en", clk_en, d >= CONV_CYCLES && d < CONV_CYCLES + n);
    check("latch", latch, d == l);
    check("sample_valid", sample_valid, d == l + 1);
    check("busy", busy, d >= 0 && d <= l + 1);
    check("overrun", overrun, ov);
  endtask
  task automatic cycles(input int k, input bit rnd_bits, input bit rnd_clear);
    repeat (k) begin
      if (rnd_bits) bits_18 = 1'($urandom);
      clear_overrun = rnd_clear ? ($urandom_range(0, 15) == 0) : 1'b0;
      tick();
    end
    clear_overrun = 1'b0;
  endtask
  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    cycles(3, 0, 0);
    bits_18 = 1'b1; two_lane = 1'b0; period = 16'd100; enable = 1'b1;
    cycles(230, 0, 0);
    enable = 1'b0;
    cycles(40, 0, 0);
    bits_18 = 1'b0; two_lane = 1'b1; period = 16'd24; enable = 1'b1;
    cycles(120, 0, 0);
    enable = 1'b0;
    cycles(40, 0, 0);
    bits_18 = 1'b1; two_lane = 1'b0; period = 16'd20; enable = 1'b1;
    cycles(100, 0, 0);
    cycles(150, 0, 1);
    enable = 1'b0;
    cycles(40, 0, 0);
    period = 16'd60; enable = 1'b1;
    cycles(240, 1, 0);
    enable = 1'b0;
    cycles(40, 0, 0);
    enable = 1'b1;
    cycles(7, 0, 0);
    enable = 1'b0;
    cycles(60, 0, 0);
    enable = 1'b1;
    cycles(17, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; enable = 1'b0;
    cycles(40, 0, 0);
    repeat (4000) begin
      if ($urandom_range(0, 199) == 0) begin
        enable = ~enable;
        if (!enable) period = CNT_W'($urandom_range(0, 40));
      end
      if ($urandom_range(0, 19) == 0) bits_18 = 1'($urandom);
      if ($urandom_range(0, 19) == 0) two_lane = 1'($urandom);
      clear_overrun = $urandom_range(0, 15) == 0;
      rst_n = $urandom_range(0, 399) != 0;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
